// File: rtl/demux_4x1_n_reg.sv
// Registered 1-to-4 demultiplexer: routes a shared BITS-wide bus into four held
// channel registers, tracks per-frame writes and pulses pronto on frame completion.
module demux_4x1_n_reg #(
  parameter int BITS = 7
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            zera,
  input  logic            carrega,
  input  logic            modo,
  input  logic [1:0]      SEL,
  input  logic [BITS-1:0] D_IN,
  output logic [BITS-1:0] Q3,
  output logic [BITS-1:0] Q2,
  output logic [BITS-1:0] Q1,
  output logic [BITS-1:0] Q0,
  output logic [1:0]      SLOT,
  output logic [3:0]      atualizado,
  output logic            pronto
);

  logic [BITS-1:0] chan_q [4];
  logic [BITS-1:0] chan_d [4];
  logic [1:0]      slot_q, slot_d;
  logic [3:0]      flags_q, flags_d;
  logic            pronto_q, pronto_d;
  logic [1:0]      target;
  logic [3:0]      next_flags;

  always_comb begin
    chan_d     = chan_q;
    slot_d     = slot_q;
    flags_d    = flags_q;
    pronto_d   = 1'b0;
    target     = modo ? slot_q : SEL;
    next_flags = flags_q | (4'b0001 << target);

    if (zera) begin
      // Frame restart wins over a coincident write; channel data is kept.
      slot_d  = 2'b00;
      flags_d = 4'b0000;
    end else if (carrega) begin
      chan_d[target] = D_IN;
      if (next_flags == 4'b1111) begin
        flags_d  = 4'b0000;
        pronto_d = 1'b1;
      end else begin
        flags_d = next_flags;
      end
      if (modo) begin
        slot_d = slot_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        chan_q[i] <= {BITS{1'b1}};
      end
      slot_q   <= 2'b00;
      flags_q  <= 4'b0000;
      pronto_q <= 1'b0;
    end else begin
      chan_q   <= chan_d;
      slot_q   <= slot_d;
      flags_q  <= flags_d;
      pronto_q <= pronto_d;
    end
  end

  assign Q0         = chan_q[0];
  assign Q1         = chan_q[1];
  assign Q2         = chan_q[2];
  assign Q3         = chan_q[3];
  assign SLOT       = slot_q;
  assign atualizado = flags_q;
  assign pronto     = pronto_q;

endmodule

// File: tb/tb_demux_4x1_n_reg.sv
// Bench for demux_4x1_n_reg: directed frame scenarios followed by random traffic,
// all compared against an array-based reference model after every clock edge.
module tb_demux_4x1_n_reg;

  localparam int BITS = 7;

  logic            clock = 1'b0;
  logic            reset, zera, carrega, modo;
  logic [1:0]      SEL;
  logic [BITS-1:0] D_IN;
  logic [BITS-1:0] Q3, Q2, Q1, Q0;
  logic [1:0]      SLOT;
  logic [3:0]      atualizado;
  logic            pronto;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int m_q [4];
  int m_slot;
  int m_flags;
  int m_pronto;

  int saved_q2;

  demux_4x1_n_reg #(.BITS(BITS)) dut (
    .clock      (clock),
    .reset      (reset),
    .zera       (zera),
    .carrega    (carrega),
    .modo       (modo),
    .SEL        (SEL),
    .D_IN       (D_IN),
    .Q3         (Q3),
    .Q2         (Q2),
    .Q1         (Q1),
    .Q0         (Q0),
    .SLOT       (SLOT),
    .atualizado (atualizado),
    .pronto     (pronto)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model a single clock edge from the behavioural rules.
  task automatic model_edge(input int r, input int z, input int c, input int m,
                            input int sel, input int d);
    int t;
    int nf;
    if (r != 0) begin
      for (int i = 0; i < 4; i++) m_q[i] = (1 << BITS) - 1;
      m_slot   = 0;
      m_flags  = 0;
      m_pronto = 0;
    end else if (z != 0) begin
      m_slot   = 0;
      m_flags  = 0;
      m_pronto = 0;
    end else if (c != 0) begin
      t      = (m != 0) ? m_slot : sel;
      m_q[t] = d;
      nf     = m_flags | (1 << t);
      if (nf == 15) begin
        m_flags  = 0;
        m_pronto = 1;
      end else begin
        m_flags  = nf;
        m_pronto = 0;
      end
      if (m != 0) m_slot = (m_slot + 1) % 4;
    end else begin
      m_pronto = 0;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".Q0"},   32'(Q0),         32'(m_q[0]));
    check({tag, ".Q1"},   32'(Q1),         32'(m_q[1]));
    check({tag, ".Q2"},   32'(Q2),         32'(m_q[2]));
    check({tag, ".Q3"},   32'(Q3),         32'(m_q[3]));
    check({tag, ".SLOT"}, 32'(SLOT),       32'(m_slot));
    check({tag, ".flag"}, 32'(atualizado), 32'(m_flags));
    check({tag, ".pron"}, 32'(pronto),     32'(m_pronto));
  endtask

  task automatic step(input string tag, input int r, input int z, input int c,
                      input int m, input int sel, input int d);
    reset   = 1'(r);
    zera    = 1'(z);
    carrega = 1'(c);
    modo    = 1'(m);
    SEL     = 2'(sel);
    D_IN    = BITS'(d);
    @(posedge clock);
    model_edge(r, z, c, m, sel, d);
    #1;
    compare_all(tag);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) m_q[i] = 0;
    m_slot = 0; m_flags = 0; m_pronto = 0;

    // 1. reset
    step("rst0", 1, 0, 0, 0, 0, 0);
    step("rst1", 1, 0, 0, 0, 0, 0);
    check("rst.Q0", 32'(Q0), 32'h7F);
    check("rst.Q3", 32'(Q3), 32'h7F);
    check("rst.flags", 32'(atualizado), 32'h0);

    // 2. external select
    step("ext0", 0, 0, 1, 0, 2, 'h12);
    check("ext0.Q2", 32'(Q2), 32'h12);
    check("ext0.flags", 32'(atualizado), 32'b0100);
    step("ext1", 0, 0, 1, 0, 0, 'h34);
    check("ext1.flags", 32'(atualizado), 32'b0101);
    step("ext2", 0, 0, 1, 0, 3, 'h56);
    check("ext2.flags", 32'(atualizado), 32'b1101);
    check("ext2.pronto", 32'(pronto), 32'h0);
    step("ext3", 0, 0, 1, 0, 1, 'h78);
    check("ext3.Q1", 32'(Q1), 32'h78);
    check("ext3.pronto", 32'(pronto), 32'h1);
    check("ext3.flags", 32'(atualizado), 32'h0);
    check("ext3.SLOT", 32'(SLOT), 32'h0);
    step("ext_idle", 0, 0, 0, 0, 0, 0);
    check("ext_idle.pronto", 32'(pronto), 32'h0);

    // 3. auto mode with wrap
    for (int i = 1; i <= 5; i++) begin
      step("auto", 0, 0, 1, 1, 0, i);
      if (i == 4) begin
        check("auto4.Q0", 32'(Q0), 32'h1);
        check("auto4.Q3", 32'(Q3), 32'h4);
        check("auto4.pronto", 32'(pronto), 32'h1);
      end
    end
    check("auto5.Q0", 32'(Q0), 32'h5);
    check("auto5.SLOT", 32'(SLOT), 32'h1);
    check("auto5.flags", 32'(atualizado), 32'b0001);
    check("auto5.pronto", 32'(pronto), 32'h0);

    // 4. duplicate write in a fresh frame
    step("dup_z", 0, 1, 0, 0, 0, 0);
    step("dup0", 0, 0, 1, 0, 1, 'h0A);
    step("dup1", 0, 0, 1, 0, 1, 'h0B);
    check("dup1.Q1", 32'(Q1), 32'h0B);
    check("dup1.flags", 32'(atualizado), 32'b0010);
    step("dup2", 0, 0, 1, 0, 0, 'h21);
    step("dup3", 0, 0, 1, 0, 2, 'h22);
    check("dup3.pronto", 32'(pronto), 32'h0);
    step("dup4", 0, 0, 1, 0, 3, 'h23);
    check("dup4.pronto", 32'(pronto), 32'h1);

    // 5. zera beats carrega
    step("zc_z", 0, 1, 0, 1, 0, 0);
    step("zc0", 0, 0, 1, 1, 0, 'h31);
    step("zc1", 0, 0, 1, 1, 0, 'h32);
    check("zc1.SLOT", 32'(SLOT), 32'h2);
    check("zc1.flags", 32'(atualizado), 32'b0011);
    saved_q2 = int'(Q2);
    step("zc2", 0, 1, 1, 1, 0, 'h55);
    check("zc2.Q2", 32'(Q2), 32'(saved_q2));
    check("zc2.SLOT", 32'(SLOT), 32'h0);
    check("zc2.flags", 32'(atualizado), 32'h0);
    check("zc2.pronto", 32'(pronto), 32'h0);

    // 6. reset mid-frame
    for (int i = 0; i < 3; i++) step("mid", 0, 0, 1, 1, 0, 'h40 + i);
    step("mid_rst", 1, 0, 1, 1, 0, 'h11);
    check("mid_rst.Q1", 32'(Q1), 32'h7F);
    check("mid_rst.SLOT", 32'(SLOT), 32'h0);
    check("mid_rst.pronto", 32'(pronto), 32'h0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      step("rand",
           ($urandom_range(99) < 2) ? 1 : 0,
           ($urandom_range(99) < 6) ? 1 : 0,
           ($urandom_range(99) < 75) ? 1 : 0,
           ($urandom_range(99) < 50) ? 1 : 0,
           int'($urandom_range(3)),
           int'($urandom_range(127)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
